// File: rtl/imm_encoder.sv
// Packs a 32-bit constant into the 24-bit immediate field for a given class.
// IMM_ENC_FAST_EN selects a single-cycle parallel DP rotation search.
module imm_encoder #(
  parameter int ROT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  input  logic [1:0]  imm_src,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic [23:0] imm
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]  state;
  logic [31:0] val_q;
  logic [1:0]  src_q;
  logic [31:0] cand;
  logic        dp_fin;
  logic        dp_hit;
  logic [3:0]  dp_rot;
  logic [7:0]  dp_byte;
  logic        fin;
  logic        res_ok;
  logic [23:0] res_imm;

  function automatic logic [31:0] rotl2(
    input logic [31:0] v,
    input logic [3:0]  r
  );
    logic [5:0] sh;
    sh = {1'b0, r, 1'b0};
    return (v << sh) | (v >> (6'd32 - sh));
  endfunction

`ifdef IMM_ENC_FAST_EN
  // Scan high to low so the smallest hitting rotation is the one kept.
  always_comb begin
    cand    = '0;
    dp_hit  = 1'b0;
    dp_rot  = '0;
    dp_byte = '0;
    dp_fin  = 1'b1;
    for (int i = ROT_LIMIT - 1; i >= 0; i--) begin
      cand = rotl2(val_q, 4'(i));
      if (cand[31:8] == 24'd0) begin
        dp_hit  = 1'b1;
        dp_rot  = 4'(i);
        dp_byte = cand[7:0];
      end
    end
  end
`else
  localparam logic [3:0] ROT_LAST = 4'(ROT_LIMIT - 1);

  logic [3:0] rot;

  always_comb begin
    cand    = rotl2(val_q, rot);
    dp_hit  = (cand[31:8] == 24'd0);
    dp_rot  = rot;
    dp_byte = cand[7:0];
    dp_fin  = dp_hit || (rot == ROT_LAST);
  end
`endif

  always_comb begin
    fin     = 1'b1;
    res_ok  = 1'b0;
    res_imm = '0;
    unique case (1'b1)
      (src_q == 2'b00): begin
        fin     = dp_fin;
        res_ok  = dp_hit;
        res_imm = {12'b0, dp_rot, dp_byte};
      end
      (src_q == 2'b01): begin
        res_ok  = (val_q[31:12] == 20'd0);
        res_imm = {12'b0, val_q[11:0]};
      end
      (src_q == 2'b10): begin
        res_ok  = (val_q[1:0] == 2'b00) &&
                  ((val_q[31:25] == 7'd0) || (&val_q[31:25]));
        res_imm = val_q[25:2];
      end
      (src_q == 2'b11): begin
        res_ok  = (val_q[31:5] == 27'd0);
        res_imm = {12'b0, val_q[4:0], 7'b0};
      end
      default: ;
    endcase
  end

  assign busy = (state == S_SEARCH);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      val_q <= '0;
      src_q <= '0;
      ok    <= 1'b0;
      imm   <= '0;
`ifndef IMM_ENC_FAST_EN
      rot   <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            val_q <= value;
            src_q <= imm_src;
`ifndef IMM_ENC_FAST_EN
            rot   <= '0;
`endif
            state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (fin) begin
            ok    <= res_ok;
            imm   <= res_ok ? res_imm : 24'd0;
            state <= S_DONE;
          end
`ifndef IMM_ENC_FAST_EN
          else begin
            rot <= rot + 4'd1;
          end
`endif
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized + directed bench for imm_encoder against a range/rotation model.
// Build with IMM_ENC_FAST_EN to check the single-cycle DP variant.
module tb_imm_encoder;

  localparam int ROT  = 16;
  localparam int NCYC = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic [1:0]  imm_src;
  logic        busy;
  logic        done;
  logic        ok;
  logic [23:0] imm;

  int checks = 0;
  int errors = 0;

  logic        ob_busy [0:NCYC];
  logic        ob_done [0:NCYC];
  logic        ob_ok   [0:NCYC];
  logic [23:0] ob_imm  [0:NCYC];

  always #5 clk = ~clk;

  imm_encoder #(.ROT_LIMIT(ROT)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .value(value),
    .imm_src(imm_src),
    .busy(busy),
    .done(done),
    .ok(ok),
    .imm(imm)
  );

  // Reference: encodability as numeric ranges, DP by bitwise rotation.
  function automatic void model(
    input  logic [31:0] v,
    input  logic [1:0]  s,
    output logic        o,
    output logic [23:0] im,
    output int          lat
  );
    logic [31:0] c;
    int          sv;
    o   = 1'b0;
    im  = '0;
    lat = 2;
    case (s)
      2'd0: begin
        lat = ROT + 1;
        for (int r = 0; r < ROT; r++) begin
          c = v;
          repeat (2 * r) c = {c[30:0], c[31]};
          if (!o && c < 256) begin
            o   = 1'b1;
            im  = 24'(r * 256 + int'(c));
            lat = r + 2;
          end
        end
`ifdef IMM_ENC_FAST_EN
        lat = 2;
`endif
      end
      2'd1: if (v < 4096) begin o = 1'b1; im = 24'(v); end
      2'd2: begin
        sv = int'(v);
        if (v % 4 == 0 && sv >= -(1 << 25) && sv < (1 << 25)) begin
          o  = 1'b1;
          im = 24'(sv >>> 2);
        end
      end
      default: if (v < 32) begin o = 1'b1; im = 24'(v * 128); end
    endcase
  endfunction

  task automatic run_op(
    input logic [31:0] v,
    input logic [1:0]  s,
    input int          restart_at,
    input int          reset_at
  );
    @(negedge clk);
    start   = 1'b1;
    value   = v;
    imm_src = s;
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge clk);
      ob_busy[c] = busy;
      ob_done[c] = done;
      ob_ok[c]   = ok;
      ob_imm[c]  = imm;
      start   = (c == restart_at);
      reset   = (c == reset_at);
      value   = $urandom;
      imm_src = 2'($urandom);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  function automatic void observe(
    input  int lat,
    output int first,
    output int n,
    output bit busy_good
  );
    first     = -1;
    n         = 0;
    busy_good = 1'b1;
    for (int c = 1; c <= NCYC; c++) begin
      if (ob_done[c] === 1'b1) begin
        n++;
        if (first < 0) first = c;
      end
      if (ob_busy[c] !== (c < lat)) busy_good = 1'b0;
    end
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    value = '0;
    imm_src = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ok !== 1'b0 || imm !== 24'd0) begin
      errors++;
      $display("FAIL reset got busy=%b done=%b ok=%b imm=%h want 0 0 0 000000",
               busy, done, ok, imm);
    end
    reset = 1'b0;
  endtask

  task automatic test_dp;
    logic [31:0] vals [7] = '{32'h000000FF, 32'hFF000000, 32'h00000101,
                              32'h00000000, 32'hC000003F, 32'h000003FC,
                              32'h80000001};
    logic eo; logic [23:0] ei; int lat, first, n; bit bg;
    foreach (vals[i]) begin
      model(vals[i], 2'd0, eo, ei, lat);
      run_op(vals[i], 2'd0, -1, -1);
      observe(lat, first, n, bg);
      checks++;
      if (n !== 1 || first !== lat) begin
        errors++;
        $display("FAIL dp_latency v=%h got done_at=%0d count=%0d want %0d x1",
                 vals[i], first, n, lat);
      end
      checks++;
      if (ob_ok[lat] !== eo || ob_imm[lat] !== ei ||
          ob_ok[NCYC] !== eo || ob_imm[NCYC] !== ei) begin
        errors++;
        $display("FAIL dp_result v=%h got ok=%b imm=%h want ok=%b imm=%h",
                 vals[i], ob_ok[lat], ob_imm[lat], eo, ei);
      end
      checks++;
      if (!bg) begin
        errors++;
        $display("FAIL dp_busy v=%h got wrong busy pattern want 1 for cycles 1..%0d",
                 vals[i], lat - 1);
      end
    end
  endtask

  task automatic test_classes;
    logic [31:0] tv [8] = '{32'h00000FFF, 32'h00001000, 32'hFFFFFFF8,
                            32'h00000006, 32'h02000000, 32'h01FFFFFC,
                            32'h0000001F, 32'h00000020};
    logic [1:0]  ts [8] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
    logic eo; logic [23:0] ei; int lat, first, n; bit bg;
    foreach (tv[i]) begin
      model(tv[i], ts[i], eo, ei, lat);
      run_op(tv[i], ts[i], -1, -1);
      observe(lat, first, n, bg);
      checks++;
      if (n !== 1 || first !== 2 || !bg) begin
        errors++;
        $display("FAIL class%0d_timing v=%h got done_at=%0d count=%0d busy_ok=%0d want 2 x1",
                 ts[i], tv[i], first, n, bg);
      end
      checks++;
      if (ob_ok[2] !== eo || ob_imm[2] !== ei) begin
        errors++;
        $display("FAIL class%0d_result v=%h got ok=%b imm=%h want ok=%b imm=%h",
                 ts[i], tv[i], ob_ok[2], ob_imm[2], eo, ei);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic eo; logic [23:0] ei; int lat, first, n; bit bg;
    model(32'h00000101, 2'd0, eo, ei, lat);
    run_op(32'h00000101, 2'd0, 3, -1);
    observe(lat, first, n, bg);
    checks++;
    if (n !== 1 || first !== lat || ob_ok[lat] !== eo || ob_imm[lat] !== ei) begin
      errors++;
      $display("FAIL ignore_busy got done_at=%0d count=%0d ok=%b want %0d x1 ok=%b",
               first, n, ob_ok[lat], lat, eo);
    end
    model(32'h000000AB, 2'd1, eo, ei, lat);
    run_op(32'h000000AB, 2'd1, 2, -1);
    observe(lat, first, n, bg);
    checks++;
    if (n !== 1 || first !== 2 || ob_imm[NCYC] !== ei) begin
      errors++;
      $display("FAIL ignore_done got done_at=%0d count=%0d imm=%h want 2 x1 imm=%h",
               first, n, ob_imm[NCYC], ei);
    end
  endtask

  task automatic test_reset_mid;
    logic eo; logic [23:0] ei; int lat, first, n; bit bg;
    run_op(32'h00000FFF, 2'd1, -1, -1);
    run_op(32'h00000101, 2'd0, -1, 5);
    observe(0, first, n, bg);
    checks++;
    if (n !== 0 || ob_busy[6] !== 1'b0 || ob_ok[6] !== 1'b0 || ob_imm[6] !== 24'd0) begin
      errors++;
      $display("FAIL reset_mid got dones=%0d busy=%b ok=%b imm=%h want 0 0 0 000000",
               n, ob_busy[6], ob_ok[6], ob_imm[6]);
    end
    model(32'hFF000000, 2'd0, eo, ei, lat);
    run_op(32'hFF000000, 2'd0, -1, -1);
    observe(lat, first, n, bg);
    checks++;
    if (n !== 1 || first !== lat || ob_ok[lat] !== eo || ob_imm[lat] !== ei) begin
      errors++;
      $display("FAIL after_reset got done_at=%0d ok=%b imm=%h want %0d ok=%b imm=%h",
               first, ob_ok[lat], ob_imm[lat], lat, eo, ei);
    end
  endtask

  task automatic test_random;
    logic [31:0] v; logic [1:0] s; logic [7:0] b;
    logic eo; logic [23:0] ei; int lat, first, n; bit bg;
    for (int k = 0; k < 150; k++) begin
      s = 2'($urandom);
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: begin
          b = 8'($urandom);
          v = {24'd0, b};
          repeat ($urandom_range(0, 31)) v = {v[0], v[31:1]};
        end
        2: v = $urandom_range(0, 8191);
        default: begin
          v = 32'($urandom_range(0, 1 << 26)) - 32'(1 << 25);
          if ($urandom_range(0, 1) == 1) v[1:0] = 2'b00;
        end
      endcase
      model(v, s, eo, ei, lat);
      run_op(v, s, -1, -1);
      observe(lat, first, n, bg);
      checks++;
      if (n !== 1 || first !== lat || !bg || ob_ok[lat] !== eo || ob_imm[lat] !== ei) begin
        errors++;
        $display("FAIL random v=%h src=%0d got done_at=%0d n=%0d busy_ok=%0d ok=%b imm=%h want %0d ok=%b imm=%h",
                 v, s, first, n, bg, ob_ok[lat], ob_imm[lat], lat, eo, ei);
      end
    end
  endtask

  initial begin
    test_reset;
    test_dp;
    test_classes;
    test_ignore_start;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate extend path: takes a 32-bit constant plus an immediate class and produces the 24-bit instruction immediate field that the decoder expands back to the same constant.
- Used by the instruction builder / program loader to pack operands into instructions.
- Data-processing class runs a sequential rotation search, one candidate per cycle.
- Start/done handshake with an encodability flag.

Parameters:
ROT_LIMIT, 16, number of rotation candidates examined for the DP class (1..16); candidates r = 0..ROT_LIMIT-1.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request pulse; accepted only in IDLE
value  input  32  constant to encode
imm_src  input  2  class: 00 DP rotated, 01 MEM 12-bit, 10 branch 24-bit word offset, 11 shift amount
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse when the result is valid
ok  output  1  1 = value encodable in the class; valid with done, held afterwards
imm  output  24  encoded field; valid with done, held until the next accepted start

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, ok=0, imm=0, rotation counter=0. Reset mid-search aborts with no done pulse.
- FSM: IDLE -> SEARCH -> DONE -> IDLE.
- IDLE:
  - start=1 latches value and imm_src, clears rot=0, goes to SEARCH.
  - start while busy or in DONE is ignored; it is not queued.
- SEARCH, DP class (00):
  - cand = value rotated left by 2*rot.
  - Hit if cand[31:8]==0: imm={12'b0, rot[3:0], cand[7:0]}, ok=1, go to DONE.
  - Miss: rot+1. After candidate ROT_LIMIT-1 misses: imm=0, ok=0, go to DONE.
  - The smallest hitting rot always wins.
  - Value 0 hits at rot=0.
- SEARCH, MEM class (01): single cycle. ok = value[31:12]==0. imm={12'b0, value[11:0]}. Go to DONE.
- SEARCH, branch class (10): single cycle. ok = value[1:0]==0 and value[31:26] all equal value[25]. imm=value[25:2]. Go to DONE.
- SEARCH, shift class (11): single cycle. ok = value[31:5]==0. imm={12'b0, value[4:0], 7'b0}, i.e. amount in imm[11:7]. Go to DONE.
- On fail (any class): imm=0.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE. A start seen in DONE is ignored.
- Latency from the start cycle (cycle 0):
  - DP hit at rot r: done at cycle r+2.
  - DP fail: done at cycle ROT_LIMIT+1 (17 at default).
  - Other classes: done at cycle 2.
- busy=1 in every SEARCH cycle.
- Round-trip invariant: on ok=1, feeding imm with the same imm_src through the extend path reproduces value exactly (branch class: value with bits[1:0]=0).

Optional Feature:
- Macro IMM_ENC_FAST_EN.
- Defined: all ROT_LIMIT DP candidates are evaluated in parallel in the single SEARCH cycle; the lowest hitting rot is chosen by priority. Every class completes with done at cycle 2; the rotation counter is removed.
- Undefined: sequential search as above.
- ok and imm results are identical in both builds; only latency differs.

Test Plan:
- DP value=0x000000FF -> done at cycle 2, ok=1, imm=0x0000FF.
- DP value=0xFF000000 -> done at cycle 6, ok=1, imm=0x0004FF. DP value=0x00000101 -> done at cycle 17, ok=0, imm=0.
- MEM value=0x00000FFF -> ok=1, imm=0x000FFF. MEM value=0x00001000 -> ok=0, imm=0.
- Branch value=0xFFFFFFF8 -> ok=1, imm=0xFFFFFE. Branch value=0x00000006 -> ok=0. Branch value=0x02000000 -> ok=0.
- Shift value=0x1F -> ok=1, imm=0x000F80. Shift value=0x20 -> ok=0.
- Control cases:
  - DP value=0x00000101: start asserted again at cycle 3 is ignored, still a single done at cycle 17.
  - Reset asserted at cycle 5 -> no done; busy/ok/imm=0 from the next cycle; a new start then encodes normally.
  - With IMM_ENC_FAST_EN defined, the DP 0xFF000000 case completes at cycle 2 with imm=0x0004FF.
